// File: rtl/mult_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue controller.
// Controller state encodings and datapath widths.
package mult_issue_ctrl_pkg;

    localparam int MUL_W  = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/mult_issue_ctrl_mul.sv
// Sequential radix-2 Booth multiplier, signed MUL_W x MUL_W.
// Loads on start, iterates MUL_W cycles with busy high, then holds.
module mult_issue_ctrl_mul
    import mult_issue_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic              busy,
    output logic [PROD_W-1:0] product
);

    logic [MUL_W-1:0] acc;
    logic [MUL_W-1:0] q;
    logic [MUL_W-1:0] m;
    logic             q_1;
    logic [3:0]       count;
    logic [MUL_W:0]   sum;

    assign busy    = (count != 4'd0);
    assign product = {acc, q};

    // Booth add/subtract on a sign-extended accumulator so -128 never overflows
    always_comb begin
        sum = {acc[MUL_W-1], acc};
        unique case ({q[0], q_1})
            2'b01:   sum = {acc[MUL_W-1], acc} + {m[MUL_W-1], m};
            2'b10:   sum = {acc[MUL_W-1], acc} - {m[MUL_W-1], m};
            default: sum = {acc[MUL_W-1], acc};
        endcase
    end

    // Load operands on start, then arithmetic-shift one step per cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            q_1   <= 1'b0;
            count <= 4'd0;
        end else if (start) begin
            acc   <= '0;
            q     <= b;
            m     <= a;
            q_1   <= 1'b0;
            count <= 4'(MUL_W);
        end else if (busy) begin
            acc   <= sum[MUL_W:1];
            q     <= {sum[0], q[MUL_W-1:1]};
            q_1   <= q[0];
            count <= count - 4'd1;
        end
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/retire controller in front of the Booth multiplier.
// Request port in, one-deep response slot out, plus a hold register.
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int MUL_CYCLES = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [MUL_W-1:0]  req_a,
    input  logic [MUL_W-1:0]  req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_product,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              proto_err
);

    localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt;
    logic [MUL_W-1:0]  op_a;
    logic [MUL_W-1:0]  op_b;
    logic [TAG_W-1:0]  op_tag;
    logic [PROD_W-1:0] hold_product;
    logic [TAG_W-1:0]  hold_tag;
    logic              start;
    logic              mul_busy;
    logic [PROD_W-1:0] mul_product;
    logic              slot_free;
    logic              done;

    assign slot_free = !rsp_valid || rsp_ready;
    assign done      = (state_q == RUN) && (cnt == CNT_LAST);

    mult_issue_ctrl_mul u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .product (mul_product)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, request ready and the single-cycle start pulse
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LOAD;
            end
            LOAD: begin
                start   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST)
                    state_d = slot_free ? IDLE : HOLD;
            end
            HOLD: begin
                if (slot_free) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch and iteration counter; operands stay put until next accept
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_a   <= '0;
            op_b   <= '0;
            op_tag <= '0;
            cnt    <= 4'd0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                op_a   <= req_a;
                op_b   <= req_b;
                op_tag <= req_tag;
            end
            if (state_q == LOAD)     cnt <= 4'd0;
            else if (state_q == RUN) cnt <= cnt + 4'd1;
        end
    end

    // Response slot, with the hold register parking a result when it is full
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_product <= '0;
            hold_tag     <= '0;
            rsp_valid    <= 1'b0;
            rsp_product  <= '0;
            rsp_tag      <= '0;
        end else begin
            if (done && !slot_free) begin
                hold_product <= mul_product;
                hold_tag     <= op_tag;
            end
            if (done && slot_free) begin
                rsp_valid   <= 1'b1;
                rsp_product <= mul_product;
                rsp_tag     <= op_tag;
            end else if (state_q == HOLD && slot_free) begin
                rsp_valid   <= 1'b1;
                rsp_product <= hold_product;
                rsp_tag     <= hold_tag;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid   <= 1'b0;
            end
        end
    end

    // Sticky flag when busy is not high at window start or low at window end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            proto_err <= 1'b0;
        end else if (state_q == RUN) begin
            if ((cnt == 4'd0 && !mul_busy) ||
                (cnt == CNT_LAST && mul_busy))
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed testbench for mult_issue_ctrl.
// Table of single ops, then hand-written slot/hold/reset/stream sequences.
module tb_mult_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = '0;
    logic [7:0]  req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_product;
    logic [3:0]  rsp_tag;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  tag;
        logic [15:0] prod;
    } vec_t;

    vec_t tbl [8];

    always #5 CLK = ~CLK;

    mult_issue_ctrl #(
        .TAG_W      (4),
        .MUL_CYCLES (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_tag     (rsp_tag),
        .proto_err   (proto_err)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Present a request at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [3:0] t,
                         input bit keep,
                         output int waited);
        req_a     = a;
        req_b     = b;
        req_tag   = t;
        req_valid = 1'b1;
        waited    = 0;
        while (!req_ready && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        @(negedge CLK);
        if (!keep) req_valid = 1'b0;
    endtask

    // Result must appear exactly after accept edge + 10
    task automatic expect_rsp(input string nm,
                              input logic [15:0] prod,
                              input logic [3:0] t);
        wait_neg(9);
        chk({nm, "_early"}, 32'(rsp_valid), 32'd0);
        wait_neg(1);
        chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_prod"}, 32'(rsp_product), 32'(prod));
        chk({nm, "_tag"}, 32'(rsp_tag), 32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit saw;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [3:0]  rt;
        logic [15:0] re;

        tbl[0] = '{8'h07, 8'hFD, 4'd5,  16'hFFEB};
        tbl[1] = '{8'h80, 8'h80, 4'd1,  16'h4000};
        tbl[2] = '{8'h7F, 8'h7F, 4'd2,  16'h3F01};
        tbl[3] = '{8'h00, 8'hFF, 4'd3,  16'h0000};
        tbl[4] = '{8'h80, 8'h7F, 4'd4,  16'hC080};
        tbl[5] = '{8'hFF, 8'hFF, 4'd6,  16'h0001};
        tbl[6] = '{8'h0C, 8'hF6, 4'd15, 16'hFF88};
        tbl[7] = '{8'h7F, 8'h80, 4'd7,  16'hC080};

        #2 RST = 1'b1;
        wait_neg(2);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_product", 32'(rsp_product), 32'd0);
        chk("rst_tag", 32'(rsp_tag), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        RST = 1'b0;
        wait_neg(1);

        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].tag, 1'b0, w);
            expect_rsp($sformatf("tbl%0d", i),
                       tbl[i].prod, tbl[i].tag);
        end
        chk("tbl_proto_err", 32'(proto_err), 32'd0);
        wait_neg(1);

        // Full slot: first result parked in rsp, second in HOLD
        rsp_ready = 1'b0;
        issue(8'd3, 8'd4, 4'd1, 1'b0, w);
        expect_rsp("s3_first", 16'h000C, 4'd1);
        issue(8'hFE, 8'h05, 4'd2, 1'b0, w);
        wait_neg(5);
        chk("s3_busy_ready", 32'(req_ready), 32'd0);
        chk("s3_stable_prod", 32'(rsp_product), 32'h000C);
        wait_neg(6);
        chk("s3_hold_ready", 32'(req_ready), 32'd0);
        chk("s3_hold_valid", 32'(rsp_valid), 32'd1);
        chk("s3_hold_prod", 32'(rsp_product), 32'h000C);
        chk("s3_hold_tag", 32'(rsp_tag), 32'd1);
        rsp_ready = 1'b1;
        wait_neg(1);
        chk("s3_second_valid", 32'(rsp_valid), 32'd1);
        chk("s3_second_prod", 32'(rsp_product), 32'hFFF6);
        chk("s3_second_tag", 32'(rsp_tag), 32'd2);
        chk("s3_idle_ready", 32'(req_ready), 32'd1);
        wait_neg(1);
        chk("s3_drained", 32'(rsp_valid), 32'd0);

        // Drain and refill on the same edge
        rsp_ready = 1'b0;
        issue(8'd5, 8'd6, 4'd3, 1'b0, w);
        expect_rsp("s4_first", 16'h001E, 4'd3);
        issue(8'hF9, 8'h08, 4'd4, 1'b0, w);
        wait_neg(9);
        chk("s4_pre_prod", 32'(rsp_product), 32'h001E);
        rsp_ready = 1'b1;
        wait_neg(1);
        chk("s4_same_edge_valid", 32'(rsp_valid), 32'd1);
        chk("s4_same_edge_prod", 32'(rsp_product), 32'hFFC8);
        chk("s4_same_edge_tag", 32'(rsp_tag), 32'd4);
        wait_neg(1);
        chk("s4_drained", 32'(rsp_valid), 32'd0);

        // Reset in the middle of the iteration window
        issue(8'd11, 8'd11, 4'd8, 1'b0, w);
        wait_neg(5);
        RST = 1'b1;
        #1;
        chk("s5_rst_valid", 32'(rsp_valid), 32'd0);
        chk("s5_rst_ready", 32'(req_ready), 32'd1);
        chk("s5_rst_prod", 32'(rsp_product), 32'd0);
        chk("s5_rst_tag", 32'(rsp_tag), 32'd0);
        wait_neg(1);
        RST = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (rsp_valid) saw = 1'b1;
        end
        chk("s5_no_rsp", 32'(saw), 32'd0);
        issue(8'd9, 8'd9, 4'd9, 1'b0, w);
        expect_rsp("s5_after", 16'h0051, 4'd9);
        chk("s5_proto_err", 32'(proto_err), 32'd0);
        wait_neg(1);

        // Continuous stream of random ops
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rt = 4'($urandom);
            re = 16'(int'($signed(ra)) * int'($signed(rb)));
            issue(ra, rb, rt, 1'b1, w);
            if (i > 0) chk("s6_spacing", 32'(w), 32'd0);
            expect_rsp($sformatf("s6_%0d", i), re, rt);
        end
        req_valid = 1'b0;
        chk("s6_proto_err", 32'(proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
